// File: rtl/serial_slave_if.sv
// Serial slave with a 2**ADDR_WIDTH x 8 local memory.
// Frames carry R/W, then LSB-first address; write data rides alongside the address bits.
module serial_slave_if #(
   parameter int unsigned ADDR_WIDTH = 12,
   parameter int unsigned DATA_WIDTH = 8
) (
   input  logic clk,
   input  logic reset,
   input  logic valid,
   input  logic address,
   input  logic data,
   output logic ready,
   output logic data_out
);

   localparam int unsigned CNT_W = $clog2(ADDR_WIDTH + 1);
   localparam int unsigned BIT_W = $clog2(DATA_WIDTH);
   localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      RX_ADDR = 3'd1,
      EXEC    = 3'd2,
      WR_ACK  = 3'd3,
      RD_TX   = 3'd4
   } state_t;

   state_t                  state_q;
   logic                    rw_q;
   logic                    valid_q;
   logic [CNT_W-1:0]        cnt_q;
   logic [ADDR_WIDTH-1:0]   addr_q;
   logic [DATA_WIDTH-1:0]   wdata_q;
   logic [DATA_WIDTH-1:0]   rdata_q;
   logic [DATA_WIDTH-1:0]   mem [DEPTH];
   logic                    mem_we_c;

   // The reset term keeps a write from landing on an edge that coincides with reset.
   assign mem_we_c = (state_q == EXEC) && rw_q && reset;

   // Memory has no reset so its contents survive a reset pulse.
   always_ff @(posedge clk) begin
      if (mem_we_c) begin
         mem[addr_q] <= wdata_q;
      end
   end

   // Frame control; valid_q tracks the previous cycle for 0->1 frame detection.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= IDLE;
         rw_q     <= 1'b0;
         valid_q  <= 1'b0;
         cnt_q    <= '0;
         addr_q   <= '0;
         wdata_q  <= '0;
         rdata_q  <= '0;
         ready    <= 1'b0;
         data_out <= 1'b0;
      end else begin
         valid_q <= valid;
         unique case (state_q)
            IDLE: begin
               ready    <= 1'b0;
               data_out <= 1'b0;
               if (valid && !valid_q) begin
                  rw_q    <= address;
                  cnt_q   <= '0;
                  state_q <= RX_ADDR;
               end
            end
            RX_ADDR: begin
               if (!valid) begin
                  cnt_q   <= '0;
                  state_q <= IDLE;
               end else begin
                  addr_q[cnt_q] <= address;
                  if (cnt_q < CNT_W'(DATA_WIDTH)) begin
                     wdata_q[cnt_q[BIT_W-1:0]] <= data;
                  end
                  cnt_q <= cnt_q + CNT_W'(1);
                  if (cnt_q == CNT_W'(ADDR_WIDTH - 1)) begin
                     state_q <= EXEC;
                  end
               end
            end
            EXEC: begin
               ready <= 1'b1;
               cnt_q <= '0;
               if (rw_q) begin
                  state_q <= WR_ACK;
               end else begin
                  rdata_q  <= mem[addr_q];
                  data_out <= mem[addr_q][0];
                  state_q  <= RD_TX;
               end
            end
            WR_ACK: begin
               ready   <= 1'b0;
               state_q <= IDLE;
            end
            RD_TX: begin
               if (cnt_q == CNT_W'(DATA_WIDTH - 1)) begin
                  ready    <= 1'b0;
                  data_out <= 1'b0;
                  cnt_q    <= '0;
                  state_q  <= IDLE;
               end else begin
                  data_out <= rdata_q[BIT_W'(cnt_q[BIT_W-1:0] + BIT_W'(1))];
                  cnt_q    <= cnt_q + CNT_W'(1);
               end
            end
            default: begin
               ready    <= 1'b0;
               data_out <= 1'b0;
               state_q  <= IDLE;
            end
         endcase
      end
   end

endmodule
